// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the N-way intersection controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2,
        FLASH  = 2'd3
    } phase_e;

    localparam int LAMP_W = 3;

    // Lamp field order is {R,Y,G}.
    localparam logic [LAMP_W-1:0] LAMP_RED = 3'b100;
    localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
    localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b001;
    localparam logic [LAMP_W-1:0] LAMP_OFF = 3'b000;

    function automatic int max_dur(int a, int b, int c, int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Sensor/preempt inputs and lamp-driver outputs of one intersection controller.
interface traffic_light_ctrl_if #(
    parameter int N_DIR = 4
) ();
    localparam int DIR_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;

    logic [N_DIR-1:0]   req;
    logic               preempt;
    logic [DIR_W-1:0]   preempt_dir;
    logic               flash;
    logic [N_DIR*3-1:0] light;
    logic [DIR_W-1:0]   active_dir;
    logic [1:0]         phase;

    modport master (
        output req, preempt, preempt_dir, flash,
        input  light, active_dir, phase
    );

    modport slave (
        input  req, preempt, preempt_dir, flash,
        output light, active_dir, phase
    );
endinterface

// File: rtl/rr_next_dir.sv
// Round-robin search of the demand vector, starting one past the active direction.
module rr_next_dir #(
    parameter int N_DIR = 4,
    parameter int DIR_W = 2
) (
    input  logic [N_DIR-1:0] req,
    input  logic [DIR_W-1:0] active_dir,
    output logic [DIR_W-1:0] next_dir,
    output logic             found
);
    logic [DIR_W-1:0] idx;

    function automatic logic [DIR_W-1:0] step(logic [DIR_W-1:0] d);
        return (d == DIR_W'(N_DIR - 1)) ? '0 : d + DIR_W'(1);
    endfunction

    // Only the other N_DIR-1 directions are searched; with no hit, next_dir is the plain successor.
    always_comb begin
        found    = 1'b0;
        idx      = step(active_dir);
        next_dir = idx;
        for (int off = 1; off < N_DIR; off++) begin
            if (!found && req[idx]) begin
                found    = 1'b1;
                next_dir = idx;
            end
            idx = step(idx);
        end
    end
endmodule

// File: rtl/traffic_light_ctrl.sv
// N-way intersection controller: timed green/yellow/all-red rotation with demand
// skipping, emergency preemption and night flashing; all outputs come from flops.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int N_DIR      = 4,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 4,
    parameter int ALLRED_CYC = 1,
    parameter int FLASH_HALF = 2,
    parameter int SKIP_EN    = 1
) (
    input logic                 clk,
    input logic                 reset,
    traffic_light_ctrl_if.slave bus
);
    localparam int DIR_W   = (N_DIR > 1) ? $clog2(N_DIR) : 1;
    localparam int MAX_DUR = max_dur(GREEN_CYC, YELLOW_CYC, ALLRED_CYC, FLASH_HALF);
    localparam int CNT_W   = $clog2(MAX_DUR) + 1;

    localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] F_LAST = CNT_W'(FLASH_HALF - 1);

    phase_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIR_W-1:0]   active_dir_q, active_dir_d;
    logic [DIR_W-1:0]   next_dir_q, next_dir_d;
    logic               flash_on_q, flash_on_d;
    logic [N_DIR*3-1:0] light_q, light_d;

    logic [DIR_W-1:0]   rr_dir;
    logic               rr_found;
    logic [DIR_W-1:0]   dir_inc;
    logic [DIR_W-1:0]   pick_dir;

    rr_next_dir #(
        .N_DIR (N_DIR),
        .DIR_W (DIR_W)
    ) u_rr (
        .req        (bus.req),
        .active_dir (active_dir_q),
        .next_dir   (rr_dir),
        .found      (rr_found)
    );

    assign dir_inc  = (active_dir_q == DIR_W'(N_DIR - 1)) ? '0 : active_dir_q + DIR_W'(1);
    assign pick_dir = (SKIP_EN != 0) ? rr_dir : dir_inc;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        active_dir_d = active_dir_q;
        next_dir_d   = next_dir_q;
        flash_on_d   = flash_on_q;
        case (state_q)
            GREEN: begin
                if (bus.preempt && bus.preempt_dir != active_dir_q) begin
                    state_d    = YELLOW;
                    cnt_d      = '0;
                    next_dir_d = pick_dir;
                end else if (bus.preempt) begin
                    cnt_d = '0;
                end else if (cnt_q == G_LAST) begin
                    cnt_d = '0;
                    if (SKIP_EN == 0 || rr_found) begin
                        state_d    = YELLOW;
                        next_dir_d = pick_dir;
                    end
                end
            end
            YELLOW: begin
                if (cnt_q == Y_LAST) begin
                    state_d = ALLRED;
                    cnt_d   = '0;
                end
            end
            ALLRED: begin
                if (cnt_q == A_LAST) begin
                    cnt_d = '0;
                    if (bus.preempt) begin
                        state_d      = GREEN;
                        active_dir_d = bus.preempt_dir;
                    end else if (bus.flash) begin
                        state_d    = FLASH;
                        flash_on_d = 1'b1;
                    end else begin
                        state_d      = GREEN;
                        active_dir_d = next_dir_q;
                    end
                end
            end
            FLASH: begin
                // Preemption leaves flash through a full all-red clearance.
                if (bus.preempt || !bus.flash) begin
                    state_d = ALLRED;
                    cnt_d   = '0;
                    if (!bus.preempt) next_dir_d = '0;
                end else if (cnt_q == F_LAST) begin
                    cnt_d      = '0;
                    flash_on_d = ~flash_on_q;
                end
            end
            default: begin
                state_d = ALLRED;
                cnt_d   = '0;
            end
        endcase
    end

    function automatic logic [LAMP_W-1:0] lamp_of(phase_e st, logic is_active, logic on);
        case (st)
            GREEN:   return is_active ? LAMP_GRN : LAMP_RED;
            YELLOW:  return is_active ? LAMP_YEL : LAMP_RED;
            FLASH:   return on ? LAMP_YEL : LAMP_OFF;
            default: return LAMP_RED;
        endcase
    endfunction

    // Lamps are decoded from next-state values so the registered copy matches state_q.
    for (genvar d = 0; d < N_DIR; d++) begin : g_lamp
        assign light_d[3*d +: 3] = lamp_of(state_d, active_dir_d == DIR_W'(d), flash_on_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ALLRED;
            cnt_q        <= '0;
            active_dir_q <= '0;
            next_dir_q   <= '0;
            flash_on_q   <= 1'b1;
            light_q      <= {N_DIR{LAMP_RED}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            active_dir_q <= active_dir_d;
            next_dir_q   <= next_dir_d;
            flash_on_q   <= flash_on_d;
            light_q      <= light_d;
        end
    end

    assign bus.light      = light_q;
    assign bus.active_dir = active_dir_q;
    assign bus.phase      = state_q;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: a non-skipping and a skipping instance share stimulus
// and are compared against a countdown-timer model of the intersection.
module tb_traffic_light_ctrl;
    localparam int N = 4, GRN = 8, YEL = 4, AR = 1, FH = 2;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic       preempt;
    logic [1:0] pdir;
    logic       flash;

    traffic_light_ctrl_if #(.N_DIR(N)) bus0 ();
    traffic_light_ctrl_if #(.N_DIR(N)) bus1 ();

    assign bus0.req = req;  assign bus0.preempt = preempt;  assign bus0.preempt_dir = pdir;  assign bus0.flash = flash;
    assign bus1.req = req;  assign bus1.preempt = preempt;  assign bus1.preempt_dir = pdir;  assign bus1.flash = flash;

    traffic_light_ctrl #(.N_DIR(N), .GREEN_CYC(GRN), .YELLOW_CYC(YEL), .ALLRED_CYC(AR),
                         .FLASH_HALF(FH), .SKIP_EN(0))
        dut0 (.clk(clk), .reset(reset_n), .bus(bus0));
    traffic_light_ctrl #(.N_DIR(N), .GREEN_CYC(GRN), .YELLOW_CYC(YEL), .ALLRED_CYC(AR),
                         .FLASH_HALF(FH), .SKIP_EN(1))
        dut1 (.clk(clk), .reset(reset_n), .bus(bus1));

    logic [11:0] o_light [2];
    logic [1:0]  o_ph    [2];
    logic [1:0]  o_dir   [2];
    assign o_light[0] = bus0.light;  assign o_ph[0] = bus0.phase;  assign o_dir[0] = bus0.active_dir;
    assign o_light[1] = bus1.light;  assign o_ph[1] = bus1.phase;  assign o_dir[1] = bus1.active_dir;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase (0 G,1 Y,2 AR,3 FL), direction, queued next direction,
    // cycles remaining in the timed phase, cycles elapsed in flash. Index 1 skips.
    int m_ph [2], m_dir [2], m_next [2], m_rem [2], m_ft [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic bool_other_req_dummy(); return 0; endfunction

    function automatic int other_req(int k);
        for (int d = 0; d < N; d++)
            if (d != m_dir[k] && req[2'(d)]) return 1;
        return 0;
    endfunction

    function automatic int pick(int k);
        if (k == 1)
            for (int off = 1; off < N; off++)
                if (req[2'((m_dir[k] + off) % N)]) return (m_dir[k] + off) % N;
        return (m_dir[k] + 1) % N;
    endfunction

    function automatic logic [11:0] model_light(int k);
        logic [11:0] l;
        logic [2:0]  lamp;
        l = '0;
        for (int d = 0; d < N; d++) begin
            case (m_ph[k])
                0:       lamp = (d == m_dir[k]) ? 3'b001 : 3'b100;
                1:       lamp = (d == m_dir[k]) ? 3'b010 : 3'b100;
                2:       lamp = 3'b100;
                default: lamp = (((m_ft[k] / FH) % 2) == 0) ? 3'b010 : 3'b000;
            endcase
            l = {lamp, l[11:3]};
        end
        return l;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = 2; m_dir[k] = 0; m_next[k] = 0; m_rem[k] = AR; m_ft[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            case (m_ph[k])
                0: begin
                    if (preempt && int'(pdir) != m_dir[k]) begin
                        m_next[k] = pick(k); m_ph[k] = 1; m_rem[k] = YEL;
                    end else if (preempt) begin
                        m_rem[k] = GRN;
                    end else if (m_rem[k] == 1) begin
                        if (k == 1 && other_req(k) == 0) m_rem[k] = GRN;
                        else begin m_next[k] = pick(k); m_ph[k] = 1; m_rem[k] = YEL; end
                    end else m_rem[k]--;
                end
                1: if (m_rem[k] == 1) begin m_ph[k] = 2; m_rem[k] = AR; end else m_rem[k]--;
                2: begin
                    if (m_rem[k] == 1) begin
                        if (preempt) begin m_ph[k] = 0; m_dir[k] = int'(pdir); m_rem[k] = GRN; end
                        else if (flash) begin m_ph[k] = 3; m_ft[k] = 0; end
                        else begin m_ph[k] = 0; m_dir[k] = m_next[k]; m_rem[k] = GRN; end
                    end else m_rem[k]--;
                end
                default: begin
                    if (preempt) begin m_ph[k] = 2; m_rem[k] = AR; end
                    else if (!flash) begin m_ph[k] = 2; m_rem[k] = AR; m_next[k] = 0; end
                    else m_ft[k]++;
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req = '0; preempt = 1'b0; pdir = '0; flash = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = '0; preempt = 1'b0; pdir = '0; flash = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (o_light[k] !== 12'h924 || o_ph[k] !== 2'd2 || o_dir[k] !== 2'd0) begin
                n_bad++;
                $display("FAIL reset_state dut%0d light=%h phase=%0d dir=%0d required light=924 phase=2 dir=0",
                         k, o_light[k], o_ph[k], o_dir[k]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        do_reset();
        for (int c = 1; c <= 60; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (o_light[k] !== model_light(k) || o_ph[k] !== 2'(m_ph[k]) || o_dir[k] !== 2'(m_dir[k])) begin
                    n_bad++;
                    $display("FAIL basic_model dut%0d cyc=%0d light=%h/%h phase=%0d/%0d dir=%0d/%0d (got/required)",
                             k, c, o_light[k], model_light(k), o_ph[k], m_ph[k], o_dir[k], m_dir[k]);
                end
            end
            if (c == 1 || c == 13 || c == 14 || c == 53) begin
                logic [11:0] want;
                want = (c == 13) ? 12'h924 : (c == 14) ? 12'h90C : 12'h921;
                n_cmp++;
                if (o_light[0] !== want) begin
                    n_bad++;
                    $display("FAIL basic_timeline cyc=%0d light=%h required=%h", c, o_light[0], want);
                end
            end
            if (c == 53) begin
                n_cmp++;
                if (o_light[1] !== 12'h921 || o_ph[1] !== 2'd0) begin
                    n_bad++;
                    $display("FAIL skip_hold_no_req light=%h phase=%0d required light=921 phase=0", o_light[1], o_ph[1]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int found;
        do_reset();
        found = 0;
        for (int c = 1; c <= 100 && found == 0; c++) begin
            tick();
            if (o_ph[0] == 2'd1 && o_dir[0] == 2'd2) found = c;
        end
        n_cmp++;
        if (found != 35) begin
            n_bad++;
            $display("FAIL async_reach_yellow2 cycle=%0d required=35", found);
        end
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (o_light[k] !== 12'h924 || o_ph[k] !== 2'd2 || o_dir[k] !== 2'd0) begin
                n_bad++;
                $display("FAIL async_reset dut%0d light=%h phase=%0d dir=%0d required light=924 phase=2 dir=0",
                         k, o_light[k], o_ph[k], o_dir[k]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_skip();
        do_reset();
        req = 4'b1000;
        for (int c = 1; c <= 30; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (o_light[k] !== model_light(k) || o_ph[k] !== 2'(m_ph[k]) || o_dir[k] !== 2'(m_dir[k])) begin
                    n_bad++;
                    $display("FAIL skip_model dut%0d cyc=%0d light=%h/%h phase=%0d/%0d dir=%0d/%0d (got/required)",
                             k, c, o_light[k], model_light(k), o_ph[k], m_ph[k], o_dir[k], m_dir[k]);
                end
            end
            if (c == 14) begin
                n_cmp++;
                if (o_light[1] !== 12'h324 || o_dir[1] !== 2'd3) begin
                    n_bad++;
                    $display("FAIL skip_to_dir3 light=%h dir=%0d required light=324 dir=3", o_light[1], o_dir[1]);
                end
            end
        end
    endtask

    task automatic test_preempt();
        int greens;
        do_reset();
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 3) begin preempt = 1'b1; pdir = 2'd2; end
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (o_light[k] !== model_light(k) || o_ph[k] !== 2'(m_ph[k]) || o_dir[k] !== 2'(m_dir[k])) begin
                    n_bad++;
                    $display("FAIL preempt_model dut%0d cyc=%0d light=%h/%h phase=%0d/%0d dir=%0d/%0d (got/required)",
                             k, c, o_light[k], model_light(k), o_ph[k], m_ph[k], o_dir[k], m_dir[k]);
                end
            end
            if (c == 4 || c == 7 || c == 8 || c == 9 || c == 30) begin
                logic [1:0] wph;
                wph = (c == 4 || c == 7) ? 2'd1 : (c == 8) ? 2'd2 : 2'd0;
                n_cmp++;
                if (o_ph[0] !== wph) begin
                    n_bad++;
                    $display("FAIL preempt_timeline cyc=%0d phase=%0d required=%0d", c, o_ph[0], wph);
                end
            end
        end
        n_cmp++;
        if (o_light[0] !== 12'h864) begin
            n_bad++;
            $display("FAIL preempt_hold light=%h required=864", o_light[0]);
        end
        preempt = 1'b0;
        greens = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_ph[0] != 2'd0) break;
            greens++;
        end
        n_cmp++;
        if (greens != GRN || o_ph[0] !== 2'd1) begin
            n_bad++;
            $display("FAIL preempt_release green_cycles=%0d phase=%0d required green_cycles=%0d phase=1",
                     greens, o_ph[0], GRN);
        end
    endtask

    task automatic test_flash();
        int entry;
        do_reset();
        for (int c = 1; c <= 14; c++) tick();
        flash = 1'b1;
        entry = 0;
        for (int c = 15; c <= 60 && entry == 0; c++) begin
            tick();
            if (o_ph[0] == 2'd3) entry = c;
            n_cmp++;
            if (o_light[0] !== model_light(0) || o_ph[0] !== 2'(m_ph[0])) begin
                n_bad++;
                $display("FAIL flash_model cyc=%0d light=%h/%h phase=%0d/%0d (got/required)",
                         c, o_light[0], model_light(0), o_ph[0], m_ph[0]);
            end
        end
        n_cmp++;
        if (entry != 27 || o_light[0] !== 12'h492) begin
            n_bad++;
            $display("FAIL flash_entry cycle=%0d light=%h required cycle=27 light=492", entry, o_light[0]);
        end
        for (int i = 1; i <= 8; i++) begin
            logic [11:0] want;
            tick();
            want = (((i / FH) % 2) == 0) ? 12'h492 : 12'h000;
            n_cmp++;
            if (o_light[0] !== want) begin
                n_bad++;
                $display("FAIL flash_blink step=%0d light=%h required=%h", i, o_light[0], want);
            end
        end
        flash = 1'b0;
        tick();
        n_cmp++;
        if (o_light[0] !== 12'h924 || o_ph[0] !== 2'd2) begin
            n_bad++;
            $display("FAIL flash_exit_allred light=%h phase=%0d required light=924 phase=2", o_light[0], o_ph[0]);
        end
        tick();
        n_cmp++;
        if (o_light[0] !== 12'h921 || o_dir[0] !== 2'd0) begin
            n_bad++;
            $display("FAIL flash_exit_dir0 light=%h dir=%0d required light=921 dir=0", o_light[0], o_dir[0]);
        end
    endtask

    task automatic test_priority();
        do_reset();
        flash = 1'b1;
        for (int c = 1; c <= 4; c++) tick();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (o_ph[k] !== 2'd3) begin
                n_bad++;
                $display("FAIL prio_in_flash dut%0d phase=%0d required=3", k, o_ph[k]);
            end
        end
        preempt = 1'b1; pdir = 2'd3;
        tick();
        n_cmp++;
        if (o_light[0] !== 12'h924 || o_ph[0] !== 2'd2) begin
            n_bad++;
            $display("FAIL prio_allred light=%h phase=%0d required light=924 phase=2", o_light[0], o_ph[0]);
        end
        for (int c = 0; c < 12; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (o_light[k] !== 12'h324 || o_ph[k] !== 2'd0 || o_dir[k] !== 2'd3) begin
                    n_bad++;
                    $display("FAIL prio_preempt_green dut%0d step=%0d light=%h phase=%0d dir=%0d required light=324 phase=0 dir=3",
                             k, c, o_light[k], o_ph[k], o_dir[k]);
                end
            end
        end
        preempt = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (o_light[k] !== model_light(k) || o_ph[k] !== 2'(m_ph[k]) || o_dir[k] !== 2'(m_dir[k])) begin
                    n_bad++;
                    $display("FAIL prio_model dut%0d step=%0d light=%h/%h phase=%0d/%0d dir=%0d/%0d (got/required)",
                             k, c, o_light[k], model_light(k), o_ph[k], m_ph[k], o_dir[k], m_dir[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 1; c <= 1500; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (o_light[k] !== model_light(k) || o_ph[k] !== 2'(m_ph[k]) || o_dir[k] !== 2'(m_dir[k])) begin
                    n_bad++;
                    $display("FAIL random_model dut%0d cyc=%0d light=%h/%h phase=%0d/%0d dir=%0d/%0d (got/required)",
                             k, c, o_light[k], model_light(k), o_ph[k], m_ph[k], o_dir[k], m_dir[k]);
                end
            end
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) preempt = ~preempt;
            if (preempt && $urandom_range(0, 15) == 0) pdir = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) flash = ~flash;
            if ($urandom_range(0, 399) == 0) begin
                #2;
                reset_n = 1'b0;
                #1;
                n_cmp++;
                if (o_light[0] !== 12'h924 || o_ph[0] !== 2'd2) begin
                    n_bad++;
                    $display("FAIL random_async_reset light=%h phase=%0d required light=924 phase=2", o_light[0], o_ph[0]);
                end
                @(negedge clk);
                reset_n = 1'b1;
                model_reset();
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_async_reset();
        test_skip();
        test_preempt();
        test_flash();
        test_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised N-way intersection controller. It is the next generation of the fixed 4-way, fixed-timing controller, and adds:
- configurable direction count and phase durations;
- an all-red clearance interval;
- vehicle-demand skipping;
- emergency preemption;
- a night flashing mode.

It sits between the sensor/preempt input logic and the lamp drivers, one instance per intersection.

## Interface
- `N_DIR`, 4: number of approach directions (2..8).
- `GREEN_CYC`, 8: green duration in cycles (≥1).
- `YELLOW_CYC`, 4: yellow duration in cycles (≥1).
- `ALLRED_CYC`, 1: all-red clearance in cycles (≥1).
- `FLASH_HALF`, 2: flash half-period in cycles (≥1).
- `SKIP_EN`, 1: 1 = skip directions with no demand.

- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset asserted).
- `req` in `N_DIR`: per-direction vehicle demand, level-sensitive.
- `preempt` in 1: emergency preemption request, level.
- `preempt_dir` in `$clog2(N_DIR)`: target direction, valid while `preempt`=1.
- `flash` in 1: night-mode request, level.
- `light` out `N_DIR*3`: lamp codes, `{R,Y,G}` per direction, direction d at `[3d+2:3d]`; 100 = red, 010 = yellow, 001 = green.
- `active_dir` out `$clog2(N_DIR)`: direction currently green or yellow.
- `phase` out 2: 0 GREEN, 1 YELLOW, 2 ALLRED, 3 FLASH.

## Operation
- **States:** GREEN, YELLOW, ALLRED, FLASH. Registers: state, `active_dir`, `next_dir`, counter `cnt` (width `$clog2(max duration)+1`).
- **Lamp decode by state:**
  - GREEN: `active_dir` = 001, all others 100.
  - YELLOW: `active_dir` = 010, all others 100.
  - ALLRED: every direction 100.
  - FLASH: all directions 010 in "on" half-periods, 000 in "off" half-periods. The first half-period is "on".
- **Counting:** `cnt` resets to 0 on every state entry and increments each cycle. A timed state exits when `cnt == DUR-1`.
- **GREEN exit:**
  - At expiry, compute `next_dir` = first direction after `active_dir` in round-robin order with `req`=1, or `active_dir`+1 (mod `N_DIR`) when `SKIP_EN`=0.
  - If `SKIP_EN`=1 and no `req` is set on any other direction, hold green and restart `cnt`.
  - Otherwise go to YELLOW.
- **YELLOW → ALLRED** at expiry.
- **ALLRED exit** at expiry, in priority order:
  1. `preempt` → GREEN on `preempt_dir`.
  2. `flash` → FLASH.
  3. Otherwise → GREEN on `next_dir`.
- **Preemption (highest priority):**
  - `preempt`=1 during GREEN with `active_dir` ≠ `preempt_dir`: go to YELLOW on the next edge (green truncated).
  - `preempt`=1 during GREEN with `active_dir` = `preempt_dir`: hold green, `cnt` frozen at 0.
  - `preempt`=1 during YELLOW or ALLRED: these complete normally; YELLOW and ALLRED are never shortened.
  - `preempt`=1 during FLASH: go to ALLRED on the next edge.
  - On `preempt` falling, the held green runs a full `GREEN_CYC` from `cnt`=0.
- **Flash mode:**
  - `flash` is honoured only at ALLRED exit; a GREEN in progress completes its full sequence first.
  - FLASH exit when `flash`=0: go to ALLRED with `next_dir` = 0.
- **Reset:** state ALLRED, `cnt` 0, `active_dir` 0, `next_dir` 0; `light` all 100, `phase` 2.
  - Asserting `reset` mid-phase forces these values immediately (asynchronously).

## Timing
- All outputs are decoded from registered state only: no combinational path from any input to any output.
- An input sampled at edge k affects outputs after edge k, i.e. one cycle of latency.
- After reset release, the first GREEN (dir 0) appears after `ALLRED_CYC` rising edges.
- Steady cycle per direction: `GREEN_CYC` + `YELLOW_CYC` + `ALLRED_CYC` cycles.
- Simultaneous `preempt` and `flash`: preempt wins.
- A `preempt_dir` change while `preempt` is held and that direction is green is treated as a new request: the current green is truncated.
- `req` pulses shorter than the GREEN expiry sample are not latched. Demand is sampled only at GREEN expiry.

## Structure
- Package `traffic_pkg` holds:
  - `phase_e` enum (GREEN, YELLOW, ALLRED, FLASH);
  - lamp constants `LAMP_RED`, `LAMP_YEL`, `LAMP_GRN`, `LAMP_OFF`;
  - the `{R,Y,G}` field width.
- Sub-module `rr_next_dir`: combinational round-robin search of `req` starting at `active_dir`+1. Outputs `next_dir` and `found`.

## Test plan
- **Reset/basic:** `N_DIR`=4, `SKIP_EN`=0, release reset → all-red 1 cycle; then dir0 green 8, yellow 4, all-red 1; dir1 green at cycle 14; dir0 green again at cycle 53.
- **Async reset:** assert `reset` mid-YELLOW on dir2 → `light` = all 100 and `phase` = 2 in the same cycle, without a clock edge.
- **Skip:** `SKIP_EN`=1, `req`=4'b1000 while dir0 green → after dir0 all-red, dir3 goes green (dirs 1–2 skipped). With `req`=4'b0000 → dir0 green held indefinitely.
- **Preempt:** during dir0 green at `cnt`=2, `preempt`=1 with `preempt_dir`=2 → yellow next cycle for 4 cycles, all-red 1, dir2 green held while `preempt`=1; release → dir2 green exactly 8 more cycles.
- **Flash:** `flash`=1 during dir1 green → dir1 completes green, yellow, all-red; then all directions alternate 010/000 every 2 cycles. Drop `flash` → all-red 1 cycle, then dir0 green.
- **Priority:** `preempt` and `flash` rise together during FLASH → ALLRED next edge, then GREEN on `preempt_dir`, with no return to FLASH while `preempt`=1.
